// File: rtl/ov7670_stream_gen_if.sv
// OV7670 camera output bundle: pixel clock, syncs and byte data.
interface ov7670_stream_gen_if;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] data;

    modport master (output pclk, vsync, href, data);
    modport slave  (input  pclk, vsync, href, data);
endinterface

// File: rtl/ov7670_stream_gen.sv
// OV7670 QQVGA output emulator: divided pclk, frame/line timing FSM and
// RGB565 test patterns, two bytes per pixel, high byte first.
module ov7670_stream_gen #(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int PCLK_DIV   = 4,
    parameter int H_BLANK    = 144,
    parameter int VS_LINES   = 3,
    parameter int V_BACK     = 17,
    parameter int V_FRONT    = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    input  logic [15:0]           solid_rgb565,
    ov7670_stream_gen_if.master   cam,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt
);
    localparam int SLOTS = 2*IMG_WIDTH + H_BLANK;
    localparam int ACT   = 2*IMG_WIDTH;
    localparam int HALF  = PCLK_DIV/2;
    localparam int BARW  = IMG_WIDTH/8;
    localparam int DW    = $clog2(PCLK_DIV);
    localparam int BW    = $clog2(SLOTS);
    localparam int LW    = $clog2(IMG_HEIGHT + V_BACK + V_FRONT + VS_LINES + 1);
    localparam int XW    = (BARW > 1) ? $clog2(BARW) : 1;

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [BW-1:0]   bcnt, bcnt_nxt;
    logic [LW-1:0]   lcnt, lcnt_nxt;
    logic            eol, frame_end, start;
    logic [1:0]      pat_q;
    logic [15:0]     solid_q;
    logic [XW-1:0]   bar_cnt;
    logic [2:0]      bar_idx;
    logic            href_i;
    logic [15:0]     bar_rgb, pix;
    logic [4:0]      gx;
    logic [5:0]      gy;

    // Tick is the wrap of the divider, which is also the pclk falling edge.
    assign tick = (div_cnt == DW'(PCLK_DIV-1));

    // Free-running pclk divider; pclk is high for the upper half of the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            cam.pclk <= 1'b0;
        end else if (tick) begin
            div_cnt  <= '0;
            cam.pclk <= 1'b0;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
            cam.pclk <= (int'(div_cnt) + 1) >= HALF;
        end
    end

    assign eol = (bcnt == BW'(SLOTS-1));

    // Next frame/line position; zero-length back/front porches are skipped.
    always_comb begin
        state_nxt = state;
        lcnt_nxt  = lcnt;
        bcnt_nxt  = (state == IDLE || eol) ? '0 : bcnt + 1'b1;
        frame_end = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: if (enable) begin
                state_nxt = VSYNC;
                lcnt_nxt  = '0;
                start     = 1'b1;
            end
            VSYNC: if (eol) begin
                if (lcnt == LW'(VS_LINES-1)) begin
                    lcnt_nxt  = '0;
                    state_nxt = (V_BACK > 0) ? VBACK : ACTIVE;
                end else lcnt_nxt = lcnt + 1'b1;
            end
            VBACK: if (eol) begin
                if (lcnt == LW'(V_BACK-1)) begin
                    lcnt_nxt  = '0;
                    state_nxt = ACTIVE;
                end else lcnt_nxt = lcnt + 1'b1;
            end
            ACTIVE: if (eol) begin
                if (lcnt == LW'(IMG_HEIGHT-1)) begin
                    lcnt_nxt  = '0;
                    state_nxt = VFRONT;
                    frame_end = (V_FRONT == 0);
                end else lcnt_nxt = lcnt + 1'b1;
            end
            VFRONT: if (eol) begin
                if (lcnt == LW'(V_FRONT-1)) frame_end = 1'b1;
                else lcnt_nxt = lcnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (frame_end) begin
            state_nxt = enable ? VSYNC : IDLE;
            lcnt_nxt  = '0;
            start     = enable;
        end
    end

    // State, counters, per-frame latches and bar tracking advance on ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bcnt       <= '0;
            lcnt       <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
            pat_q      <= '0;
            solid_q    <= '0;
            bar_cnt    <= '0;
            bar_idx    <= '0;
        end else begin
            frame_done <= tick && frame_end;
            if (tick) begin
                state <= state_nxt;
                bcnt  <= bcnt_nxt;
                lcnt  <= lcnt_nxt;
                if (frame_end) frame_cnt <= frame_cnt + 1'b1;
                if (start) begin
                    pat_q   <= pattern_sel;
                    solid_q <= solid_rgb565;
                end
                if (!href_i) begin
                    bar_cnt <= '0;
                    bar_idx <= '0;
                end else if (bcnt[0]) begin
                    if (bar_cnt == XW'(BARW-1)) begin
                        bar_cnt <= '0;
                        bar_idx <= bar_idx + 1'b1;
                    end else bar_cnt <= bar_cnt + 1'b1;
                end
            end
        end
    end

    assign href_i = (state == ACTIVE) && (bcnt < BW'(ACT));
    assign gx     = 5'(bcnt >> 1);
    assign gy     = 6'(lcnt);

    // Pixel color for the current slot from the latched pattern.
    always_comb begin
        bar_rgb = 16'h0000;
        case (bar_idx)
            3'd0: bar_rgb = 16'hFFFF;
            3'd1: bar_rgb = 16'hFFE0;
            3'd2: bar_rgb = 16'h07FF;
            3'd3: bar_rgb = 16'h07E0;
            3'd4: bar_rgb = 16'hF81F;
            3'd5: bar_rgb = 16'hF800;
            3'd6: bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase
        pix = solid_q;
        case (pat_q)
            2'd0: pix = solid_q;
            2'd1: pix = bar_rgb;
            2'd2: pix = {gx, gy, frame_cnt[4:0]};
            default: pix = (gx[3] ^ gy[3]) ? 16'hFFFF : 16'h0000;
        endcase
    end

    assign busy      = (state != IDLE);
    assign cam.vsync = (state == VSYNC);
    assign cam.href  = href_i;
    assign cam.data  = href_i ? (bcnt[0] ? pix[7:0] : pix[15:8]) : 8'h00;
endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen on a reduced frame geometry:
// 16x12 active, 8 blank slots (40 slots/line), 3+2+12+2 = 19 lines/frame.
`timescale 1ns/1ps
module tb_ov7670_stream_gen;
    localparam int W  = 16;
    localparam int H  = 12;
    localparam int SL = 2*W + 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid_rgb565 = 16'h0000;
    logic        busy, frame_done;
    logic [15:0] frame_cnt;

    ov7670_stream_gen_if cam();

    ov7670_stream_gen #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PCLK_DIV(4), .H_BLANK(8),
        .VS_LINES(3), .V_BACK(2), .V_FRONT(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
        .solid_rgb565(solid_rgb565), .cam(cam), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // Receiver-side capture, sampled on pclk rising as a real sensor input would be.
    logic [7:0] cap [0:H-1][0:2*W-1];
    int vs_cnt = 0, line_idx = 0, byte_idx = 0, bad_bursts = 0, data_nz = 0;
    int vs_rises = 0, fd_cnt = 0;
    logic prev_vs = 1'b0, prev_href = 1'b0;

    always @(posedge cam.pclk) begin
        if (cam.vsync && !prev_vs) begin
            vs_rises++; vs_cnt = 0; line_idx = 0; bad_bursts = 0; data_nz = 0;
        end
        if (cam.vsync) vs_cnt++;
        if (cam.href) begin
            if (!prev_href) byte_idx = 0;
            if (line_idx < H && byte_idx < 2*W) cap[line_idx][byte_idx] = cam.data;
            byte_idx++;
        end else begin
            if (cam.data !== 8'h00) data_nz++;
            if (prev_href) begin
                if (byte_idx != 2*W) bad_bursts++;
                line_idx++;
            end
        end
        prev_vs   = cam.vsync;
        prev_href = cam.href;
    end

    // Counts clk cycles with frame_done high, so a stretched pulse shows up.
    always @(posedge clk) if (frame_done === 1'b1) fd_cnt++;

    function automatic logic [15:0] px(input int l, input int x);
        return {cap[l][2*x], cap[l][2*x+1]};
    endfunction

    task automatic wait_fd(input string tag);
        bit seen = 0;
        for (int i = 0; i < 8000 && !seen; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1;
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL %s frame_done timeout: got none, required a pulse", tag); end
    endtask

    task automatic wait_busy(input string tag);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b1) seen = 1;
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL %s busy timeout: busy=%b required=1", tag, busy); end
    endtask

    task automatic wait_line(input int n, input string tag);
        bit seen = 0;
        for (int i = 0; i < 8000 && !seen; i++) begin
            @(negedge clk);
            if (line_idx == n && cam.href === 1'b1) seen = 1;
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL %s line %0d timeout: line_idx=%0d", tag, n, line_idx); end
    endtask

    task automatic test_reset;
        logic idle_bad = 1'b0;
        logic exp;
        reset = 1'b1; enable = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({cam.pclk, cam.vsync, cam.href, cam.data, busy, frame_done, frame_cnt} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_vals: got pclk=%b vs=%b href=%b data=%h busy=%b fd=%b fc=%0d required all 0",
                     cam.pclk, cam.vsync, cam.href, cam.data, busy, frame_done, frame_cnt);
        end
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp = (k % 4 == 2) || (k % 4 == 3);
            n_chk++;
            if (cam.pclk !== exp) begin
                n_fail++; $display("FAIL idle_pclk k=%0d: got %b required %b", k, cam.pclk, exp);
            end
            if (cam.vsync !== 1'b0 || cam.href !== 1'b0 || cam.data !== 8'h00 ||
                busy !== 1'b0 || frame_cnt !== 16'd0) idle_bad = 1'b1;
        end
        n_chk++;
        if (idle_bad !== 1'b0) begin n_fail++; $display("FAIL idle_quiet: got activity=1 required 0"); end
    endtask

    task automatic test_solid;
        int fd0 = fd_cnt;
        int errs = 0;
        pattern_sel = 2'd0; solid_rgb565 = 16'hF800; enable = 1'b1;
        wait_busy("solid");
        n_chk++;
        if (cam.vsync !== 1'b1) begin n_fail++; $display("FAIL solid_vsync_rise: got %b required 1", cam.vsync); end
        enable = 1'b0;
        wait_fd("solid");
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL solid_busy_end: got %b required 0", busy); end
        n_chk++;
        if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL solid_frame_cnt: got %0d required 1", frame_cnt); end
        n_chk++;
        if (vs_cnt != 3*SL) begin n_fail++; $display("FAIL solid_vsync_len: got %0d required %0d", vs_cnt, 3*SL); end
        n_chk++;
        if (line_idx != H || bad_bursts != 0) begin
            n_fail++; $display("FAIL solid_bursts: got %0d lines %0d bad required %0d lines 0 bad", line_idx, bad_bursts, H);
        end
        n_chk++;
        if (data_nz != 0) begin n_fail++; $display("FAIL solid_blank_data: got %0d nonzero required 0", data_nz); end
        for (int l = 0; l < H; l++)
            for (int x = 0; x < W; x++)
                if (px(l, x) !== 16'hF800) errs++;
        n_chk++;
        if (errs != 0) begin n_fail++; $display("FAIL solid_pixels: got %0d bad pixels required 0", errs); end
        repeat (8) @(negedge clk);
        n_chk++;
        if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL solid_fd_pulse: got %0d cycles required 1", fd_cnt - fd0); end
    endtask

    task automatic test_bars;
        pattern_sel = 2'd1; enable = 1'b1;
        wait_busy("bars");
        enable = 1'b0;
        wait_fd("bars");
        n_chk++;
        if (px(0,1) !== 16'hFFFF || px(0,2) !== 16'hFFE0 || px(0,15) !== 16'h0000 || px(0,8) !== 16'hF81F) begin
            n_fail++; $display("FAIL bars_line0: got %h %h %h %h required ffff ffe0 0000 f81f", px(0,1), px(0,2), px(0,15), px(0,8));
        end
        n_chk++;
        if (px(11,1) !== 16'hFFFF || px(11,2) !== 16'hFFE0 || px(11,15) !== 16'h0000) begin
            n_fail++; $display("FAIL bars_line11: got %h %h %h required ffff ffe0 0000", px(11,1), px(11,2), px(11,15));
        end
        n_chk++;
        if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL bars_frame_cnt: got %0d required 2", frame_cnt); end
    endtask

    task automatic test_pattern_switch;
        pattern_sel = 2'd1; enable = 1'b1;
        wait_busy("switch");
        wait_line(3, "switch");
        pattern_sel = 2'd3;
        wait_fd("switch_a");
        n_chk++;
        if (px(11,2) !== 16'hFFE0 || px(5,10) !== 16'hF800) begin
            n_fail++; $display("FAIL switch_held_bars: got %h %h required ffe0 f800", px(11,2), px(5,10));
        end
        n_chk++;
        if (busy !== 1'b1 || cam.vsync !== 1'b1) begin
            n_fail++; $display("FAIL switch_back_to_back: got busy=%b vsync=%b required 1 1", busy, cam.vsync);
        end
        enable = 1'b0;
        wait_fd("switch_b");
        n_chk++;
        if (px(0,8) !== 16'hFFFF || px(8,8) !== 16'h0000 || px(0,0) !== 16'h0000 || px(8,0) !== 16'hFFFF) begin
            n_fail++; $display("FAIL switch_checker: got %h %h %h %h required ffff 0000 0000 ffff", px(0,8), px(8,8), px(0,0), px(8,0));
        end
        n_chk++;
        if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL switch_frame_cnt: got %0d required 4", frame_cnt); end
    endtask

    task automatic test_gradient;
        pattern_sel = 2'd2; enable = 1'b1;
        wait_busy("grad");
        enable = 1'b0;
        wait_fd("grad");
        n_chk++;
        if (px(3,5) !== 16'h2864 || px(11,15) !== 16'h7964) begin
            n_fail++; $display("FAIL grad_pixels: got %h %h required 2864 7964", px(3,5), px(11,15));
        end
    endtask

    task automatic test_enable_drop;
        int rises0;
        pattern_sel = 2'd0; solid_rgb565 = 16'h07E0; enable = 1'b1;
        wait_busy("drop");
        wait_line(5, "drop");
        enable = 1'b0;
        wait_fd("drop");
        n_chk++;
        if (busy !== 1'b0 || frame_cnt !== 16'd6) begin
            n_fail++; $display("FAIL drop_end: got busy=%b fc=%0d required 0 6", busy, frame_cnt);
        end
        n_chk++;
        if (line_idx != H || px(11,0) !== 16'h07E0) begin
            n_fail++; $display("FAIL drop_complete: got lines=%0d px=%h required %0d 07e0", line_idx, px(11,0), H);
        end
        rises0 = vs_rises;
        repeat (400) @(negedge clk);
        n_chk++;
        if (vs_rises != rises0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL drop_no_restart: got rises=%0d busy=%b required %0d 0", vs_rises, busy, rises0);
        end
    endtask

    task automatic test_reset_mid;
        enable = 1'b1;
        wait_busy("rst_mid");
        wait_line(6, "rst_mid");
        reset = 1'b1;
        #1;
        n_chk++;
        if ({cam.pclk, cam.vsync, cam.href, cam.data, busy, frame_done, frame_cnt} !== 28'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got pclk=%b vs=%b href=%b data=%h busy=%b fc=%0d required all 0",
                     cam.pclk, cam.vsync, cam.href, cam.data, busy, frame_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        wait_busy("rst_restart");
        n_chk++;
        if (cam.vsync !== 1'b1) begin n_fail++; $display("FAIL rst_restart_vsync: got %b required 1", cam.vsync); end
        enable = 1'b0;
        wait_fd("rst_restart");
        n_chk++;
        if (frame_cnt !== 16'd1 || vs_cnt != 3*SL || line_idx != H || bad_bursts != 0) begin
            n_fail++; $display("FAIL rst_restart_frame: got fc=%0d vs=%0d lines=%0d bad=%0d required 1 %0d %0d 0",
                               frame_cnt, vs_cnt, line_idx, bad_bursts, 3*SL, H);
        end
    endtask

    initial begin
        test_reset;
        test_solid;
        test_bars;
        test_pattern_switch;
        test_gradient;
        test_enable_drop;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
